// File: rtl/tick_bcd_counter_pkg.sv
// rtl/tick_bcd_counter_pkg.sv - shared types and seven-segment table for the tick BCD counter
package tick_counter_pkg;

   typedef enum logic {
      STOPPED = 1'b0,
      RUNNING = 1'b1
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Active-high {g,f,e,d,c,b,a}, entry 9 first so SEG_TABLE[d] selects digit d
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'b1101111,
      7'b1111111,
      7'b0000111,
      7'b1111101,
      7'b1101101,
      7'b1100110,
      7'b1001111,
      7'b1011011,
      7'b0000110,
      7'b0111111
   };

endpackage

// File: rtl/tick_bcd_counter_if.sv
// rtl/tick_bcd_counter_if.sv - control/display bundle of the tick BCD counter; dir exists only with DOWN_COUNT_EN
interface tick_bcd_counter_if;
   import tick_counter_pkg::*;

   logic       slow_clk;
   logic       start_stop;
   logic       clear;
`ifdef DOWN_COUNT_EN
   logic       dir;
`endif
   bcd_t       ones_bcd;
   bcd_t       tens_bcd;
   logic [6:0] seg_ones;
   logic [6:0] seg_tens;
   logic       running;
   logic       wrap;

   modport slave (
`ifdef DOWN_COUNT_EN
      input  dir,
`endif
      input  slow_clk,
      input  start_stop,
      input  clear,
      output ones_bcd,
      output tens_bcd,
      output seg_ones,
      output seg_tens,
      output running,
      output wrap
   );

   modport master (
`ifdef DOWN_COUNT_EN
      output dir,
`endif
      output slow_clk,
      output start_stop,
      output clear,
      input  ones_bcd,
      input  tens_bcd,
      input  seg_ones,
      input  seg_tens,
      input  running,
      input  wrap
   );

endinterface

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational BCD to active-high seven-segment decode
module seg7_decoder
   import tick_counter_pkg::*;
(
   input  bcd_t       bcd,
   output logic [6:0] seg
);

   // 10..15 cannot occur; blank them rather than show garbage
   always_comb begin
      seg = SEG_BLANK;
      if (bcd <= 4'd9) begin
         seg = SEG_TABLE[bcd];
      end
   end

endmodule

// File: rtl/tick_bcd_counter.sv
// rtl/tick_bcd_counter.sv - two-digit BCD counter of divider ticks with run/stop FSM; DOWN_COUNT_EN adds dir
module tick_bcd_counter
   import tick_counter_pkg::*;
#(
   parameter int MODULO         = 60,
   parameter bit SEG_ACTIVE_LOW = 1'b1
)
(
   input logic             clk,
   input logic             reset,
   tick_bcd_counter_if.slave bus
);

   localparam bcd_t       LAST_ONES = bcd_t'((MODULO - 1) % 10);
   localparam bcd_t       LAST_TENS = bcd_t'((MODULO - 1) / 10);
   localparam logic [6:0] SEG_ZERO  = SEG_ACTIVE_LOW ? ~SEG_TABLE[0] : SEG_TABLE[0];

   logic [2:0] slow_sync;
   logic [2:0] ss_sync;
   logic       tick;
   logic       ss_edge;
   logic       down;
   logic       at_limit;
   logic       count_en;
   state_t     state;
   state_t     state_next;
   bcd_t       ones;
   bcd_t       tens;
   logic       wrap_q;
   logic [6:0] dec_ones;
   logic [6:0] dec_tens;
   logic [6:0] seg_ones_q;
   logic [6:0] seg_tens_q;

   // bit0/bit1 synchronize, bit2 holds history for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slow_sync <= 3'b000;
         ss_sync   <= 3'b000;
      end else begin
         slow_sync <= {slow_sync[1:0], bus.slow_clk};
         ss_sync   <= {ss_sync[1:0], bus.start_stop};
      end
   end

   assign tick    = slow_sync[1] & ~slow_sync[2];
   assign ss_edge = ss_sync[1] & ~ss_sync[2];

`ifdef DOWN_COUNT_EN
   assign down = bus.dir;
`else
   assign down = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= STOPPED;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (ss_edge) begin
         state_next = (state == RUNNING) ? STOPPED : RUNNING;
      end
   end

   // Uses the pre-toggle state so a stop edge still counts its tick
   assign count_en = tick && (state == RUNNING);
   assign at_limit = down ? ((ones == 4'd0) && (tens == 4'd0))
                          : ((ones == LAST_ONES) && (tens == LAST_TENS));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ones   <= 4'd0;
         tens   <= 4'd0;
         wrap_q <= 1'b0;
      end else if (bus.clear) begin
         ones   <= 4'd0;
         tens   <= 4'd0;
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= count_en && at_limit;
         if (count_en) begin
            if (at_limit) begin
               ones <= down ? LAST_ONES : 4'd0;
               tens <= down ? LAST_TENS : 4'd0;
            end else if (down) begin
               if (ones == 4'd0) begin
                  ones <= 4'd9;
                  tens <= tens - 4'd1;
               end else begin
                  ones <= ones - 4'd1;
               end
            end else begin
               if (ones == 4'd9) begin
                  ones <= 4'd0;
                  tens <= tens + 4'd1;
               end else begin
                  ones <= ones + 4'd1;
               end
            end
         end
      end
   end

   seg7_decoder u_dec_ones (.bcd(ones), .seg(dec_ones));
   seg7_decoder u_dec_tens (.bcd(tens), .seg(dec_tens));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg_ones_q <= SEG_ZERO;
         seg_tens_q <= SEG_ZERO;
      end else begin
         seg_ones_q <= SEG_ACTIVE_LOW ? ~dec_ones : dec_ones;
         seg_tens_q <= SEG_ACTIVE_LOW ? ~dec_tens : dec_tens;
      end
   end

   assign bus.ones_bcd = ones;
   assign bus.tens_bcd = tens;
   assign bus.seg_ones = seg_ones_q;
   assign bus.seg_tens = seg_tens_q;
   assign bus.running  = (state == RUNNING);
   assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_tick_bcd_counter.sv
// tb/tb_tick_bcd_counter.sv - self-checking bench for tick_bcd_counter; honours DOWN_COUNT_EN
module tb_tick_bcd_counter;

   localparam int MOD = 60;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   tick_bcd_counter_if bus();

   tick_bcd_counter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int errors = 0;

   // Reference: integer count value, run flag, and edge events due two edges after sampling
   int edge_n = 0;
   int m_val  = 0;
   int m_prev = 0;
   bit m_run  = 1'b0;
   bit m_wrap = 1'b0;
   int tickq[$];
   int ssq[$];
   bit prev_slow = 1'b0;
   bit prev_ss   = 1'b0;
   int wrap_seen = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_exp(input int d);
      logic [6:0] p;
      case (d)
         0: p = 7'h3F;
         1: p = 7'h06;
         2: p = 7'h5B;
         3: p = 7'h4F;
         4: p = 7'h66;
         5: p = 7'h6D;
         6: p = 7'h7D;
         7: p = 7'h07;
         8: p = 7'h7F;
         9: p = 7'h6F;
         default: p = 7'h00;
      endcase
      return ~p;
   endfunction

   always @(posedge clk) begin
      bit t;
      bit s;
      bit dn;
      edge_n++;
      if (!reset) begin
         m_val = 0;
         m_prev = 0;
         m_run = 1'b0;
         m_wrap = 1'b0;
         tickq.delete();
         ssq.delete();
      end else begin
         t = 1'b0;
         s = 1'b0;
         if (tickq.size() > 0 && tickq[0] == edge_n) begin
            t = 1'b1;
            void'(tickq.pop_front());
         end
         if (ssq.size() > 0 && ssq[0] == edge_n) begin
            s = 1'b1;
            void'(ssq.pop_front());
         end
`ifdef DOWN_COUNT_EN
         dn = bus.dir;
`else
         dn = 1'b0;
`endif
         m_prev = m_val;
         m_wrap = 1'b0;
         if (bus.clear) begin
            m_val = 0;
         end else if (t && m_run) begin
            if (dn) begin
               if (m_val == 0) begin
                  m_val = MOD - 1;
                  m_wrap = 1'b1;
               end else begin
                  m_val = m_val - 1;
               end
            end else begin
               m_val = (m_val + 1) % MOD;
               m_wrap = (m_val == 0);
            end
         end
         if (s) m_run = !m_run;
      end
   end

   task automatic check_all();
      check("ones_bcd", bus.ones_bcd, m_val % 10);
      check("tens_bcd", bus.tens_bcd, m_val / 10);
      check("seg_ones", bus.seg_ones, seg_exp(m_prev % 10));
      check("seg_tens", bus.seg_tens, seg_exp(m_prev / 10));
      check("running", bus.running, m_run);
      check("wrap", bus.wrap, m_wrap);
      if (bus.wrap === 1'b1) wrap_seen++;
   endtask

   task automatic cyc(input bit s, input bit ss, input bit cl, input bit d);
      @(negedge clk);
      check_all();
      if (s && !prev_slow) tickq.push_back(edge_n + 3);
      if (ss && !prev_ss) ssq.push_back(edge_n + 3);
      prev_slow = s;
      prev_ss = ss;
      bus.slow_clk = s;
      bus.start_stop = ss;
      bus.clear = cl;
`ifdef DOWN_COUNT_EN
      bus.dir = d;
`endif
   endtask

   task automatic period(input bit do_ss, input bit do_clr, input bit d);
      for (int i = 0; i < 20; i++) begin
         cyc(i < 10, do_ss && (i < 4), do_clr && (i == 2), d);
      end
   endtask

   task automatic periods(input int n);
      for (int i = 0; i < n; i++) period(1'b0, 1'b0, 1'b0);
   endtask

   task automatic ss_pulse();
      for (int i = 0; i < 8; i++) cyc(1'b0, i < 4, 1'b0, 1'b0);
   endtask

   function automatic int dut_val();
      return 10 * int'(bus.tens_bcd) + int'(bus.ones_bcd);
   endfunction

   initial begin
      int hold;
      bit sl;
      bus.slow_clk = 1'b0;
      bus.start_stop = 1'b0;
      bus.clear = 1'b0;
`ifdef DOWN_COUNT_EN
      bus.dir = 1'b0;
`endif
      repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      repeat (100) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("idle_seg_ones", bus.seg_ones, 7'b1000000);
      check("idle_seg_tens", bus.seg_tens, 7'b1000000);
      check("idle_running", bus.running, 1'b0);

      ss_pulse();
      periods(5);
      check("run_cnt05", dut_val(), 5);
      check("run_state", bus.running, 1'b1);

      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      wrap_seen = 0;
      periods(60);
      check("wrap_once", wrap_seen, 1);
      check("wrap_cnt00", dut_val(), 0);

      periods(59);
      check("pre_clear59", dut_val(), 59);
      wrap_seen = 0;
      period(1'b0, 1'b1, 1'b0);
      check("clear_cnt00", dut_val(), 0);
      check("clear_nowrap", wrap_seen, 0);
      check("clear_running", bus.running, 1'b1);

      periods(12);
      check("pre_stop12", dut_val(), 12);
      period(1'b1, 1'b0, 1'b0);
      check("stop_cnt13", dut_val(), 13);
      check("stop_state", bus.running, 1'b0);
      periods(3);
      check("stopped_hold13", dut_val(), 13);

`ifdef DOWN_COUNT_EN
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      ss_pulse();
      wrap_seen = 0;
      period(1'b0, 1'b0, 1'b1);
      check("down_cnt59", dut_val(), 59);
      check("down_wrap", wrap_seen, 1);
      check("down_seg_tens", bus.seg_tens, ~7'h6D);
      check("down_seg_ones", bus.seg_ones, ~7'h6F);
`endif

      hold = 0;
      sl = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (hold == 0) begin
            sl = ~sl;
            hold = $urandom_range(1, 8);
         end
         hold--;
         cyc(sl, $urandom_range(0, 99) < 4, $urandom_range(0, 299) < 2, $urandom_range(0, 1) == 1);
      end

      @(negedge clk);
      reset = 1'b0;
      bus.slow_clk = 1'b0;
      bus.start_stop = 1'b0;
      bus.clear = 1'b0;
      prev_slow = 1'b0;
      prev_ss = 1'b0;
      #1;
      check("rst_ones", bus.ones_bcd, 0);
      check("rst_tens", bus.tens_bcd, 0);
      check("rst_running", bus.running, 1'b0);
      check("rst_wrap", bus.wrap, 1'b0);
      check("rst_seg_ones", bus.seg_ones, 7'b1000000);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      ss_pulse();
      periods(2);
      check("post_rst_cnt", dut_val(), 2);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/tick_bcd_counter.md
Name: tick_bcd_counter

Overview:
- Stage directly downstream of the board's frequency divider: consumes its slow square-wave output and counts its rising edges as a two-digit BCD counter.
- Result shown on two seven-segment displays.
- Run/stop controlled by a pushbutton.
- Default configuration is a 00–59 seconds counter driven by the ~1 Hz divider output on the 50 MHz board clock.

Parameters:
- MODULO, 60, count range 0..MODULO-1; legal 2..100.
- SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted (common-anode board), 0 = active-high.

Ports:
- clk  in  1  system clock (same clock that drives the divider)
- reset  in  1  asynchronous, active-low
- slow_clk  in  1  divider output, treated as data (sampled, never used as a clock)
- start_stop  in  1  pushbutton level, active-high, pre-debounced
- clear  in  1  synchronous clear, active-high level
- dir  in  1  1 = count down (present only with DOWN_COUNT_EN)
- ones_bcd  out  4  units digit, BCD
- tens_bcd  out  4  tens digit, BCD
- seg_ones  out  7  segments {g,f,e,d,c,b,a} for units digit
- seg_tens  out  7  segments {g,f,e,d,c,b,a} for tens digit
- running  out  1  1 = RUNNING state
- wrap  out  1  one-clk pulse on wrap-around

Behaviour:
- Reset asynchronous, active-low; clock clk. All state is cleared asynchronously while reset=0.
- Reset values:
  - ones_bcd = 0, tens_bcd = 0, running = 0, wrap = 0.
  - seg_* show "0": 7'b1000000 if SEG_ACTIVE_LOW=1, else 7'b0111111.
  - Synchronizer flops = 0.
- slow_clk path: 2-flop synchronizer s1→s2, plus history flop s3; tick = s2 & ~s3.
  - Latency: the count changes on the 3rd clk edge, counting the first edge that samples slow_clk = 1 as edge 1.
  - Exactly one tick per slow_clk rising edge. Falling edges are ignored.
- start_stop path: same 2-flop synchronizer plus edge detector; each rising edge toggles the state.
- FSM, 2 states:
  - STOPPED (reset state): start_stop edge → RUNNING.
  - RUNNING: start_stop edge → STOPPED.
  - running = 1 iff state is RUNNING (registered).
- Counting: on tick while RUNNING, up-count by 1.
  - Value MODULO-1 → 0, with wrap = 1 for exactly that one cycle.
  - Ones digit rolls 9→0 and carries into the tens digit.
  - Digits never leave 0..9. Value is always < MODULO.
- Priority in one cycle: clear > tick.
  - clear forces the count to 00 and suppresses wrap.
  - clear does not change the FSM state.
- Tick and start_stop edge in the same cycle: the tick is evaluated against the pre-toggle state.
  - RUNNING→STOPPED still counts that tick.
  - STOPPED→RUNNING does not count it.
- Ticks while STOPPED are discarded, not queued.
- Segment outputs: registered decode of the BCD digits; they lag ones_bcd/tens_bcd by 1 clk.
  - Digit patterns 0–9 use the standard encoding.
  - Digit values 10–15 are unreachable. Decode them to all-segments-off as a safe default.
- Reset mid-count: returns to 00 / STOPPED immediately. The first tick after release requires a fresh slow_clk rising edge seen by the synchronizer.

Optional Feature:
- Macro: DOWN_COUNT_EN.
- Defined:
  - dir port exists.
  - dir=1 counts down: 0 → MODULO-1 with wrap pulse; ones digit 0→9 with borrow from tens.
  - dir is sampled in the tick cycle; a change mid-count takes effect on the next tick.
- Undefined: no dir port; up-count only. Logic is identical to DOWN_COUNT_EN defined with dir tied 0.

Decomposition:
- Package tick_counter_pkg:
  - FSM state enum {STOPPED, RUNNING}.
  - 4-bit BCD digit typedef.
  - Active-high seven-segment constant table for digits 0–9.
  - SEG_BLANK constant.
- Sub-module seg7_decoder (BCD in, 7-bit active-high out, combinational).
  - Instantiated twice.
  - Inversion for SEG_ACTIVE_LOW and output registers live in the top.

Test Plan:
- Reset, then release with no stimulus → BCD 00, seg_ones = seg_tens = 7'b1000000, running = 0, wrap = 0 for 100 clks.
- One start_stop pulse, then slow_clk with period 20 clk (10 high/10 low), 5 periods → running = 1, count 05; each increment lands 3 clk edges after slow_clk rises.
- Running, 60 slow_clk periods from 00 → 09→10 carry seen; 59→00 with wrap high for exactly 1 clk; then count 00.
- clear asserted in the same cycle as tick at count 59 → count 00, wrap stays 0, running unchanged.
- start_stop edge coincident with a tick while RUNNING at count 12 → count 13, running = 0; a further 3 slow_clk periods leave count at 13.
- DOWN_COUNT_EN, dir=1, running from 00, one tick → count 59, wrap pulse 1 clk, seg_tens shows 5, seg_ones shows 9 one clk later.
